mem_access_ctrl: RTL and testbench

Initiator-side controller for the 256x8 synchronous-write memory (`memory_256x8`). It accepts byte read and write requests from the CPU datapath over a valid/ready handshake and drives the memory port (`we`, `addr`, `d_i`). It captures `d_o` and returns read data as a backpressured response stream. Incrementing read bursts of 1–4 bytes support multi-byte instruction fetch.

---
 rtl/mem_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Initiator-side controller for a 256x8 synchronous-write memory. It takes
// byte read/write requests over a valid/ready handshake and drives the memory
// port. Read data goes back as a backpressured response stream, with
// incrementing read bursts of 1-4 beats for multi-byte instruction fetch.
// Every output comes straight from a flop, so no input reaches an output
// combinationally.

module mem_access_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [1:0] req_len,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_last,
    output logic       wr_done,
    output logic       busy,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_d_i,
    input  logic [7:0] mem_d_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_RSP     = 3'd4
    } state_t;

    state_t     state_r;
    logic [7:0] addr_r;       // current beat address, also drives mem_addr
    logic [1:0] cnt_r;        // beats remaining after the current one
    logic [7:0] wdata_r;      // last latched write data, drives mem_d_i
    logic       req_ready_r;
    logic       busy_r;
    logic       rsp_valid_r;
    logic [7:0] rsp_data_r;
    logic       rsp_last_r;
    logic       wr_done_r;
    logic       mem_we_r;

    logic       accept_s;     // request handshake completes this edge
    logic       beat_take_s;  // response beat handshake completes this edge
    logic       more_s;       // burst has beats left after the current one

    // Handshake qualifiers derived from registered state and the inputs.
    always_comb begin
        accept_s    = 1'b0;
        beat_take_s = 1'b0;
        more_s      = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = req_valid & req_ready_r;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == ST_RSP) begin
            beat_take_s = rsp_ready;
        end else begin
            beat_take_s = 1'b0;
        end
        if (cnt_r != 2'd0) begin
            more_s = 1'b1;
        end else begin
            more_s = 1'b0;
        end
    end

    // Controller FSM: sequences the memory port and owns every registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= 8'h00;
            cnt_r       <= 2'd0;
            wdata_r     <= 8'h00;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_last_r  <= 1'b0;
            wr_done_r   <= 1'b0;
            mem_we_r    <= 1'b0;
        end else begin
            // wr_done is a single-cycle pulse; only the WR exit raises it.
            wr_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_r      <= req_addr;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (req_we) begin
                            // Writes are always single-beat; the length field is ignored.
                            cnt_r    <= 2'd0;
                            wdata_r  <= req_wdata;
                            mem_we_r <= 1'b1;
                            state_r  <= ST_WR;
                        end else begin
                            cnt_r    <= req_len;
                            mem_we_r <= 1'b0;
                            state_r  <= ST_RD_ADDR;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        mem_we_r    <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    // The memory commits on the edge that leaves this state.
                    mem_we_r    <= 1'b0;
                    wr_done_r   <= 1'b1;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                ST_RD_ADDR: begin
                    // Address has been stable one cycle; a registered-read
                    // memory presents its data during RD_DATA.
                    state_r <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    rsp_data_r  <= mem_d_o;
                    rsp_valid_r <= 1'b1;
                    rsp_last_r  <= ~more_s;
                    state_r     <= ST_RSP;
                end
                ST_RSP: begin
                    if (beat_take_s) begin
                        rsp_valid_r <= 1'b0;
                        rsp_last_r  <= 1'b0;
                        if (more_s) begin
                            // Next beat: address wraps naturally at 8 bits.
                            cnt_r   <= cnt_r - 2'd1;
                            addr_r  <= addr_r + 8'd1;
                            state_r <= ST_RD_ADDR;
                        end else begin
                            req_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= ST_IDLE;
                        end
                    end else begin
                        // Stalled: hold the beat and leave the memory quiet.
                        state_r <= ST_RSP;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a safe idle state.
                    state_r     <= ST_IDLE;
                    cnt_r       <= 2'd0;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_last_r  <= 1'b0;
                    mem_we_r    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_last  = rsp_last_r;
    assign wr_done   = wr_done_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_d_i   = wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a behavioural
// 256x8 synchronous-write, combinational-read memory attached.

module tb_mem_access_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [1:0] req_len;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic       wr_done;
    logic       busy;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_d_i;
    logic [7:0] mem_d_o;

    logic [7:0] mem [256];

    int err_cnt = 0;
    int chk_cnt = 0;

    mem_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .wr_done   (wr_done),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_d_i   (mem_d_i),
        .mem_d_o   (mem_d_o)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_d_i;
    end
    assign mem_d_o = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", req_ready, 1'b1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic [1:0] len);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_len = len;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wr_mem_we",   mem_we,    1'b1);
        chk("wr_mem_addr", mem_addr,  a);
        chk("wr_mem_d_i",  mem_d_i,   d);
        chk("wr_busy",     busy,      1'b1);
        chk("wr_ready_lo", req_ready, 1'b0);
        chk("wr_done_lo",  wr_done,   1'b0);
        @(posedge clk); #1;
        chk("wr_mem_we_off", mem_we,    1'b0);
        chk("wr_done_hi",    wr_done,   1'b1);
        chk("wr_ready_hi",   req_ready, 1'b1);
        chk("wr_busy_off",   busy,      1'b0);
        chk("wr_commit",     mem[a],    d);
        @(posedge clk); #1;
        chk("wr_done_pulse", wr_done, 1'b0);
    endtask

    // Read with rsp_ready held high; ex holds the expected beats, beat 0 in [7:0].
    task automatic do_read(input logic [7:0] a, input logic [1:0] len, input logic [31:0] ex);
        logic [7:0] ea;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = len; req_wdata = 8'h00;
        rsp_ready = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rd_busy",     busy,     1'b1);
        chk("rd_valid_e0", rsp_valid, 1'b0);
        chk("rd_mem_addr", mem_addr, a);
        chk("rd_mem_we",   mem_we,   1'b0);
        for (int b = 0; b <= int'(len); b++) begin
            ea = a + 8'(b);
            @(posedge clk); #1;
            chk("rd_valid_early", rsp_valid, 1'b0);
            @(posedge clk); #1;
            chk("rd_valid",  rsp_valid, 1'b1);
            chk("rd_data",   rsp_data,  ex[8*b +: 8]);
            chk("rd_last",   rsp_last,  (b == int'(len)) ? 1'b1 : 1'b0);
            chk("rd_addr_b", mem_addr,  ea);
            @(posedge clk); #1;
        end
        chk("rd_idle_busy",  busy,      1'b0);
        chk("rd_idle_valid", rsp_valid, 1'b0);
        chk("rd_idle_ready", req_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00;
        req_wdata = 8'h00; req_len = 2'd0; rsp_ready = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data",  rsp_data,  8'h00);
        chk("rst_rsp_last",  rsp_last,  1'b0);
        chk("rst_wr_done",   wr_done,   1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_mem_we",    mem_we,    1'b0);
        chk("rst_mem_addr",  mem_addr,  8'h00);
        chk("rst_mem_d_i",   mem_d_i,   8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single write (length field ignored) and read-back.
        do_write(8'h10, 8'hA5, 2'd3);
        do_read(8'h10, 2'd0, 32'h0000_00A5);

        // Four-beat burst.
        do_write(8'h00, 8'h11, 2'd0);
        do_write(8'h01, 8'h22, 2'd0);
        do_write(8'h02, 8'h33, 2'd0);
        do_write(8'h03, 8'h44, 2'd0);
        do_read(8'h00, 2'd3, 32'h4433_2211);

        // Busy rejection: a write held pending during a 4-beat read.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; req_len = 2'd3; rsp_ready = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h9C; req_len = 2'd2;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            chk("busy_ready_lo", req_ready, 1'b0);
            chk("busy_mem_we",   mem_we,    1'b0);
            if ((k % 3) == 2) begin
                chk("busy_beat_valid", rsp_valid, 1'b1);
                chk("busy_beat_data",  rsp_data,  8'h11 * 8'((k + 1) / 3));
            end
        end
        @(posedge clk); #1;
        chk("busy_idle_ready", req_ready, 1'b1);
        chk("busy_idle_we",    mem_we,    1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("busy_wr_we",   mem_we,   1'b1);
        chk("busy_wr_addr", mem_addr, 8'h20);
        chk("busy_wr_data", mem_d_i,  8'h9C);
        @(posedge clk); #1;
        chk("busy_wr_done", wr_done, 1'b1);
        chk("busy_mem20",   mem[8'h20], 8'h9C);
        do_read(8'h20, 2'd0, 32'h0000_009C);

        // Backpressure on beat 0 of a 2-beat read.
        do_write(8'h40, 8'h66, 2'd0);
        do_write(8'h41, 8'h77, 2'd0);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; req_len = 2'd1;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_valid0", rsp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", rsp_valid, 1'b1);
            chk("bp_hold_data",  rsp_data,  8'h66);
            chk("bp_hold_last",  rsp_last,  1'b0);
            chk("bp_hold_addr",  mem_addr,  8'h40);
            chk("bp_hold_we",    mem_we,    1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", rsp_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_beat1_valid", rsp_valid, 1'b1);
        chk("bp_beat1_data",  rsp_data,  8'h77);
        chk("bp_beat1_last",  rsp_last,  1'b1);
        @(posedge clk); #1;
        chk("bp_idle", busy, 1'b0);

        // Address wrap past 0xFF.
        do_write(8'hFF, 8'h5A, 2'd0);
        do_write(8'h00, 8'hC3, 2'd0);
        do_read(8'hFF, 2'd1, 32'h0000_C35A);

        // Reset during a write: mem_we drops at once.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h50; req_wdata = 8'hEE; req_len = 2'd0;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rw_we_before", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        chk("rw_we_after",   mem_we, 1'b0);
        chk("rw_busy_after", busy,   1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset during beat 1 of a 4-beat read.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; req_len = 2'd3; rsp_ready = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rb_busy_mid", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rb_rsp_valid", rsp_valid, 1'b0);
        chk("rb_rsp_data",  rsp_data,  8'h00);
        chk("rb_rsp_last",  rsp_last,  1'b0);
        chk("rb_busy",      busy,      1'b0);
        chk("rb_req_ready", req_ready, 1'b1);
        chk("rb_mem_we",    mem_we,    1'b0);
        chk("rb_mem_addr",  mem_addr,  8'h00);
        chk("rb_mem_d_i",   mem_d_i,   8'h00);
        chk("rb_wr_done",   wr_done,   1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rb_no_valid", rsp_valid, 1'b0);
        rst = 1'b0;
        do_write(8'h30, 8'h5C, 2'd0);
        do_read(8'h30, 2'd0, 32'h0000_005C);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
